// File: rtl/fxp_pkg.sv
// Shared Q2.14 fixed-point definitions used by the divider, the saturator and the multiplier.
package fxp_pkg;
   localparam int FXP_DATA_WIDTH = 16;
   localparam int FXP_FRAC_WIDTH = 14;
   localparam int FXP_INT_WIDTH  = FXP_DATA_WIDTH - FXP_FRAC_WIDTH;

   localparam logic [FXP_DATA_WIDTH-1:0] FXP_MAX = 16'h7FFF;
   localparam logic [FXP_DATA_WIDTH-1:0] FXP_MIN = 16'h8000;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      DONE
   } fxp_state_e;
endpackage

// File: rtl/fxp_div_if.sv
// Operand/result handshake bundle for fxp_div; master drives operands, slave is the divider.
interface fxp_div_if
   import fxp_pkg::*;
#(
   parameter int data_width = FXP_DATA_WIDTH
) ();
   logic                  in_valid;
   logic                  in_ready;
   logic [data_width-1:0] A_in;
   logic [data_width-1:0] B_in;
   logic                  out_valid;
   logic                  out_ready;
   logic [data_width-1:0] out;
   logic                  overflow_flag;
   logic                  underflow_flag;
   logic                  div_zero_flag;

   modport master (
      output in_valid, A_in, B_in, out_ready,
      input  in_ready, out_valid, out, overflow_flag, underflow_flag, div_zero_flag
   );

   modport slave (
      input  in_valid, A_in, B_in, out_ready,
      output in_ready, out_valid, out, overflow_flag, underflow_flag, div_zero_flag
   );
endinterface

// File: rtl/fxp_sat.sv
// Unsigned magnitude + sign to saturated signed word with overflow/underflow flags.
module fxp_sat
   import fxp_pkg::*;
#(
   parameter int data_width = FXP_DATA_WIDTH,
   parameter int mag_width  = 31
) (
   input  logic [mag_width-1:0]  mag,
   input  logic                  neg,
   output logic [data_width-1:0] word,
   output logic                  overflow,
   output logic                  underflow
);
   localparam logic [mag_width-1:0] POS_LIM = mag_width'((2 ** (data_width - 1)) - 1);
   localparam logic [mag_width-1:0] NEG_LIM = mag_width'(2 ** (data_width - 1));

   logic [data_width-1:0] mag_lo;
   assign mag_lo = mag[data_width-1:0];

   always_comb begin
      word      = mag_lo;
      overflow  = 1'b0;
      underflow = 1'b0;
      if (!neg) begin
         if (mag > POS_LIM) begin
            word     = POS_LIM[data_width-1:0];
            overflow = 1'b1;
         end
      end else begin
         // Magnitude of exactly 2^(w-1) negates onto itself, giving the most negative word.
         if (mag > NEG_LIM) begin
            word      = NEG_LIM[data_width-1:0];
            underflow = 1'b1;
         end else begin
            word = -mag_lo;
         end
      end
   end
endmodule

// File: rtl/fxp_div.sv
// Sequential restoring divider for signed Q2.14, one quotient bit per cycle, saturated output.
// Define FXP_DIV_ROUND_EN to add a guard iteration and round half away from zero.
module fxp_div
   import fxp_pkg::*;
#(
   parameter int data_width = FXP_DATA_WIDTH,
   parameter int frac_width = FXP_FRAC_WIDTH,
   parameter int int_width  = data_width - frac_width
) (
   input logic      clk,
   input logic      rst_n,
   fxp_div_if.slave bus
);
`ifdef FXP_DIV_ROUND_EN
   localparam int GUARD = 1;
`else
   localparam int GUARD = 0;
`endif
   localparam int ITER   = int_width + 2 * frac_width;
   localparam int N_ITER = ITER + GUARD;
   localparam int CNT_W  = $clog2(N_ITER + 1);
   localparam int MAG_W  = ITER + 1;
   localparam logic [data_width-1:0] WORD_MAX = {1'b0, {(data_width-1){1'b1}}};
   localparam logic [data_width-1:0] WORD_MIN = {1'b1, {(data_width-1){1'b0}}};

   fxp_state_e            state_q, state_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [data_width-1:0] rem_q, rem_d;
   logic [data_width-1:0] b_mag_q, b_mag_d;
   logic [N_ITER-1:0]     num_q, num_d;
   logic [N_ITER-1:0]     quo_q, quo_d;
   logic                  neg_q, neg_d;
   logic                  dz_q, dz_d;
   logic                  in_ready_q, in_ready_d;
   logic                  out_valid_q, out_valid_d;
   logic [data_width-1:0] out_q, out_d;
   logic                  ovf_q, ovf_d;
   logic                  unf_q, unf_d;
   logic                  dzf_q, dzf_d;

   logic [data_width-1:0] a_mag, b_mag;
   logic                  b_zero;
   logic [data_width:0]   rem_shift;
   logic [MAG_W-1:0]      q_mag;
   logic [data_width-1:0] sat_word;
   logic                  sat_ovf, sat_unf;

   assign a_mag  = bus.A_in[data_width-1] ? -bus.A_in : bus.A_in;
   assign b_mag  = bus.B_in[data_width-1] ? -bus.B_in : bus.B_in;
   assign b_zero = (bus.B_in == '0);

   // The guard bit is the LSB of the extended quotient; adding it rounds the magnitude half-up.
   generate
      if (GUARD != 0) begin : g_round
         assign q_mag = MAG_W'(quo_q[N_ITER-1:1]) + MAG_W'(quo_q[0]);
      end else begin : g_trunc
         assign q_mag = MAG_W'(quo_q);
      end
   endgenerate

   fxp_sat #(
      .data_width(data_width),
      .mag_width (MAG_W)
   ) u_sat (
      .mag      (q_mag),
      .neg      (neg_q),
      .word     (sat_word),
      .overflow (sat_ovf),
      .underflow(sat_unf)
   );

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      rem_d       = rem_q;
      b_mag_d     = b_mag_q;
      num_d       = num_q;
      quo_d       = quo_q;
      neg_d       = neg_q;
      dz_d        = dz_q;
      in_ready_d  = in_ready_q;
      out_valid_d = out_valid_q;
      out_d       = out_q;
      ovf_d       = ovf_q;
      unf_d       = unf_q;
      dzf_d       = dzf_q;
      rem_shift   = {rem_q, num_q[N_ITER-1]};

      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               state_d    = CALC;
               in_ready_d = 1'b0;
               b_mag_d    = b_mag;
               dz_d       = b_zero;
               neg_d      = b_zero ? bus.A_in[data_width-1]
                                   : (bus.A_in[data_width-1] ^ bus.B_in[data_width-1]);
               num_d      = N_ITER'(a_mag) << (N_ITER - data_width);
               rem_d      = '0;
               quo_d      = '0;
               // A zero divisor skips the iterations and only spends the result-register cycle.
               cnt_d      = b_zero ? CNT_W'(N_ITER) : '0;
            end
         end
         CALC: begin
            if (cnt_q == CNT_W'(N_ITER)) begin
               state_d     = DONE;
               out_valid_d = 1'b1;
               if (dz_q) begin
                  out_d = neg_q ? WORD_MIN : WORD_MAX;
                  dzf_d = 1'b1;
               end else begin
                  out_d = sat_word;
                  ovf_d = sat_ovf;
                  unf_d = sat_unf;
               end
            end else begin
               if (rem_shift >= {1'b0, b_mag_q}) begin
                  rem_d = data_width'(rem_shift - {1'b0, b_mag_q});
                  quo_d = {quo_q[N_ITER-2:0], 1'b1};
               end else begin
                  rem_d = rem_shift[data_width-1:0];
                  quo_d = {quo_q[N_ITER-2:0], 1'b0};
               end
               num_d = num_q << 1;
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d     = IDLE;
               in_ready_d  = 1'b1;
               out_valid_d = 1'b0;
               out_d       = '0;
               ovf_d       = 1'b0;
               unf_d       = 1'b0;
               dzf_d       = 1'b0;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         rem_q       <= '0;
         b_mag_q     <= '0;
         num_q       <= '0;
         quo_q       <= '0;
         neg_q       <= 1'b0;
         dz_q        <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         out_q       <= '0;
         ovf_q       <= 1'b0;
         unf_q       <= 1'b0;
         dzf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         rem_q       <= rem_d;
         b_mag_q     <= b_mag_d;
         num_q       <= num_d;
         quo_q       <= quo_d;
         neg_q       <= neg_d;
         dz_q        <= dz_d;
         in_ready_q  <= in_ready_d;
         out_valid_q <= out_valid_d;
         out_q       <= out_d;
         ovf_q       <= ovf_d;
         unf_q       <= unf_d;
         dzf_q       <= dzf_d;
      end
   end

   assign bus.in_ready       = in_ready_q;
   assign bus.out_valid      = out_valid_q;
   assign bus.out            = out_q;
   assign bus.overflow_flag  = ovf_q;
   assign bus.underflow_flag = unf_q;
   assign bus.div_zero_flag  = dzf_q;
endmodule

// File: tb/tb_fxp_div.sv
// Directed-vector bench for fxp_div; expected quotients are hand-computed Q2.14 values.
module tb_fxp_div;
   import fxp_pkg::*;

`ifdef FXP_DIV_ROUND_EN
   localparam int LAT = 32;
`else
   localparam int LAT = 31;
`endif

   logic    clk   = 1'b0;
   logic    rst_n = 1'b0;
   longint  cyc   = 0;
   int      n_cmp = 0;
   int      n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   fxp_div_if bus ();

   fxp_div dut (
      .clk  (clk),
      .rst_n(rst_n),
      .bus  (bus)
   );

   task automatic start_op(input logic [15:0] a, input logic [15:0] b, output longint acc);
      int guard = 0;
      while (bus.in_ready !== 1'b1 && guard < 100) begin
         @(posedge clk); #1;
         guard++;
      end
      if (guard >= 100) begin
         n_cmp++; n_bad++;
         $display("FAIL start_wait in_ready: got %b required 1", bus.in_ready);
      end
      bus.A_in     = a;
      bus.B_in     = b;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
      acc          = cyc;
      bus.in_valid = 1'b0;
   endtask

   task automatic wait_result(output int lat);
      lat = 0;
      while (bus.out_valid !== 1'b1 && lat < 60) begin
         @(posedge clk); #1;
         lat++;
      end
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.A_in      = '0;
      bus.B_in      = '0;
      repeat (3) @(posedge clk);
      #1;
      n_cmp++;
      if (bus.in_ready !== 1'b1) begin
         n_bad++; $display("FAIL reset in_ready: got %b required 1", bus.in_ready);
      end
      n_cmp++;
      if ({bus.out_valid, bus.out, bus.overflow_flag, bus.underflow_flag, bus.div_zero_flag} !== 20'h0) begin
         n_bad++;
         $display("FAIL reset outputs: got valid=%b out=%h flags=%b%b%b required all 0",
                  bus.out_valid, bus.out, bus.overflow_flag, bus.underflow_flag, bus.div_zero_flag);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
         n_bad++; $display("FAIL reset_release ready/valid: got %b required 10", {bus.in_ready, bus.out_valid});
      end
   endtask

   // Runs a table of operations with out_ready held high; checks latency, value, flags and return to idle.
   task automatic run_table(input string tag, input int n, input logic [15:0] av[8],
                            input logic [15:0] bv[8], input logic [15:0] ev[8],
                            input logic [2:0] fv[8], input int exp_lat);
      int     lat;
      longint acc;
      bus.out_ready = 1'b1;
      for (int i = 0; i < n; i++) begin
         start_op(av[i], bv[i], acc);
         wait_result(lat);
         $display("%s[%0d] %h / %h -> out=%h flags=%b%b%b latency=%0d", tag, i, av[i], bv[i],
                  bus.out, bus.overflow_flag, bus.underflow_flag, bus.div_zero_flag, lat);
         n_cmp++;
         if (lat != exp_lat) begin
            n_bad++; $display("FAIL %s[%0d] latency: got %0d required %0d", tag, i, lat, exp_lat);
         end
         n_cmp++;
         if (bus.out !== ev[i]) begin
            n_bad++; $display("FAIL %s[%0d] out: got %h required %h", tag, i, bus.out, ev[i]);
         end
         n_cmp++;
         if ({bus.overflow_flag, bus.underflow_flag, bus.div_zero_flag} !== fv[i]) begin
            n_bad++;
            $display("FAIL %s[%0d] flags(ovf,unf,dz): got %b%b%b required %b", tag, i,
                     bus.overflow_flag, bus.underflow_flag, bus.div_zero_flag, fv[i]);
         end
         @(posedge clk); #1;
         n_cmp++;
         if ({bus.in_ready, bus.out_valid} !== 2'b10) begin
            n_bad++; $display("FAIL %s[%0d] consume ready/valid: got %b required 10", tag, i,
                              {bus.in_ready, bus.out_valid});
         end
      end
   endtask

   task automatic test_normal();
      logic [15:0] av[8], bv[8], ev[8];
      logic [2:0]  fv[8];
      av = '{16'h2000, 16'hE000, 16'h1000, 16'h2000, 0, 0, 0, 0};
      bv = '{16'h4000, 16'h4000, 16'h3000, 16'h3000, 0, 0, 0, 0};
`ifdef FXP_DIV_ROUND_EN
      ev = '{16'h2000, 16'hE000, 16'h1555, 16'h2AAB, 0, 0, 0, 0};
`else
      ev = '{16'h2000, 16'hE000, 16'h1555, 16'h2AAA, 0, 0, 0, 0};
`endif
      fv = '{3'b000, 3'b000, 3'b000, 3'b000, 0, 0, 0, 0};
      run_table("normal", 4, av, bv, ev, fv, LAT);
   endtask

   task automatic test_saturation();
      logic [15:0] av[8], bv[8], ev[8];
      logic [2:0]  fv[8];
      av = '{16'h4000, 16'h8000, 16'hC000, 16'h4000, 16'h8000, 16'h4000, 0, 0};
      bv = '{16'h2000, 16'hC000, 16'h2000, 16'hE000, 16'h2000, 16'hC000, 0, 0};
      ev = '{16'h7FFF, 16'h7FFF, 16'h8000, 16'h8000, 16'h8000, 16'hC000, 0, 0};
      fv = '{3'b100,   3'b100,   3'b000,   3'b000,   3'b010,   3'b000,   0, 0};
      run_table("sat", 6, av, bv, ev, fv, LAT);
   endtask

   task automatic test_div_zero();
      logic [15:0] av[8], bv[8], ev[8];
      logic [2:0]  fv[8];
      av = '{16'h4000, 16'hC000, 16'h0000, 16'h8000, 0, 0, 0, 0};
      bv = '{16'h0000, 16'h0000, 16'h0000, 16'h0000, 0, 0, 0, 0};
      ev = '{FXP_MAX,  FXP_MIN,  FXP_MAX,  FXP_MIN,  0, 0, 0, 0};
      fv = '{3'b001,   3'b001,   3'b001,   3'b001,   0, 0, 0, 0};
      run_table("divzero", 4, av, bv, ev, fv, 1);
   endtask

   task automatic test_rounding();
      logic [15:0] av[8], bv[8], ev[8];
      logic [2:0]  fv[8];
      av = '{16'h0001, 16'hFFFF, 0, 0, 0, 0, 0, 0};
      bv = '{16'h7FFF, 16'h7FFF, 0, 0, 0, 0, 0, 0};
`ifdef FXP_DIV_ROUND_EN
      ev = '{16'h0001, 16'hFFFF, 0, 0, 0, 0, 0, 0};
`else
      ev = '{16'h0000, 16'h0000, 0, 0, 0, 0, 0, 0};
`endif
      fv = '{3'b000, 3'b000, 0, 0, 0, 0, 0, 0};
      run_table("round", 2, av, bv, ev, fv, LAT);
   endtask

   task automatic test_hold();
      int     lat;
      longint acc;
      bus.out_ready = 1'b0;
      start_op(16'h4000, 16'h2000, acc);
      wait_result(lat);
      for (int i = 0; i < 5; i++) begin
         $display("hold[%0d] out=%h flags=%b%b%b in_ready=%b valid=%b", i, bus.out, bus.overflow_flag,
                  bus.underflow_flag, bus.div_zero_flag, bus.in_ready, bus.out_valid);
         n_cmp++;
         if ({bus.out_valid, bus.in_ready, bus.out, bus.overflow_flag, bus.underflow_flag, bus.div_zero_flag}
             !== {2'b10, 16'h7FFF, 3'b100}) begin
            n_bad++;
            $display("FAIL hold[%0d] state: got valid=%b ready=%b out=%h flags=%b%b%b required valid=1 ready=0 out=7fff flags=100",
                     i, bus.out_valid, bus.in_ready, bus.out, bus.overflow_flag, bus.underflow_flag, bus.div_zero_flag);
         end
         @(posedge clk); #1;
      end
      bus.out_ready = 1'b1;
      @(posedge clk); #1;
      n_cmp++;
      if ({bus.in_ready, bus.out_valid, bus.overflow_flag} !== 3'b100) begin
         n_bad++; $display("FAIL hold release ready/valid/ovf: got %b required 100",
                           {bus.in_ready, bus.out_valid, bus.overflow_flag});
      end
   endtask

   task automatic test_back_to_back();
      int     lat;
      longint acc0, acc1;
      bus.out_ready = 1'b1;
      start_op(16'h2000, 16'h4000, acc0);
      wait_result(lat);
      start_op(16'hC000, 16'h2000, acc1);
      $display("b2b accept spacing=%0d", acc1 - acc0);
      n_cmp++;
      if (acc1 - acc0 != longint'(LAT + 2)) begin
         n_bad++; $display("FAIL b2b spacing: got %0d required %0d", acc1 - acc0, LAT + 2);
      end
      wait_result(lat);
      n_cmp++;
      if (bus.out !== 16'h8000 || lat != LAT) begin
         n_bad++; $display("FAIL b2b second: got out=%h lat=%0d required out=8000 lat=%0d", bus.out, lat, LAT);
      end
      @(posedge clk); #1;
   endtask

   task automatic test_reset_mid_op();
      int     lat;
      longint acc;
      bus.out_ready = 1'b0;
      start_op(16'h4000, 16'h2000, acc);
      repeat (10) begin
         @(posedge clk); #1;
      end
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.in_ready, bus.out_valid, bus.out, bus.overflow_flag, bus.underflow_flag, bus.div_zero_flag}
          !== {2'b10, 19'h0}) begin
         n_bad++; $display("FAIL rst_calc outputs: got ready=%b valid=%b out=%h required ready=1 valid=0 out=0000",
                           bus.in_ready, bus.out_valid, bus.out);
      end
      rst_n = 1'b1;
      repeat (40) begin
         @(posedge clk); #1;
      end
      n_cmp++;
      if (bus.out_valid !== 1'b0) begin
         n_bad++; $display("FAIL rst_calc stale valid: got %b required 0", bus.out_valid);
      end
      start_op(16'h4000, 16'h2000, acc);
      wait_result(lat);
      rst_n = 1'b0;
      #1;
      n_cmp++;
      if ({bus.in_ready, bus.out_valid, bus.out, bus.overflow_flag, bus.underflow_flag, bus.div_zero_flag}
          !== {2'b10, 19'h0}) begin
         n_bad++; $display("FAIL rst_done outputs: got ready=%b valid=%b out=%h flags=%b%b%b required ready=1 valid=0 out=0000 flags=000",
                           bus.in_ready, bus.out_valid, bus.out, bus.overflow_flag, bus.underflow_flag, bus.div_zero_flag);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      bus.out_ready = 1'b1;
      start_op(16'h2000, 16'h4000, acc);
      wait_result(lat);
      $display("rst_recover 2000 / 4000 -> out=%h latency=%0d", bus.out, lat);
      n_cmp++;
      if (bus.out !== 16'h2000 || lat != LAT) begin
         n_bad++; $display("FAIL rst_recover: got out=%h lat=%0d required out=2000 lat=%0d", bus.out, lat, LAT);
      end
      @(posedge clk); #1;
   endtask

   initial begin
      test_reset();
      test_normal();
      test_saturation();
      test_div_zero();
      test_rounding();
      test_hold();
      test_back_to_back();
      test_reset_mid_op();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
